// File: rtl/hazard_stall_if.sv
// hazard_stall_if: hazard events in, stall/flush controls and perf counters out
interface hazard_stall_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_WIDTH  = 32
);
  logic                  load_use_hazard;
  logic                  branch_hazard;
  logic                  memory_busy;
  logic                  muldiv_start;
  logic                  pc_write_enable;
  logic [NUM_STAGES-2:0] reg_enable;
  logic [NUM_STAGES-2:0] reg_flush;
  logic [CNT_WIDTH-1:0]  stall_cycles;
  logic [CNT_WIDTH-1:0]  flush_count;
  logic                  md_busy;
  modport master (
    output load_use_hazard, branch_hazard, memory_busy, muldiv_start,
    input  pc_write_enable, reg_enable, reg_flush, stall_cycles, flush_count, md_busy
  );
  modport slave (
    input  load_use_hazard, branch_hazard, memory_busy, muldiv_start,
    output pc_write_enable, reg_enable, reg_flush, stall_cycles, flush_count, md_busy
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: prioritised stall/flush control with mul/div wait FSM and perf counters
module hazard_stall_unit #(
  parameter int NUM_STAGES    = 5,
  parameter int LU_REG        = 1,
  parameter int BR_REG        = 2,
  parameter int MD_REG        = 2,
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_WIDTH     = 32
) (
  input logic clk,
  input logic rst,
  hazard_stall_if.slave hs
);
  localparam int NR = NUM_STAGES - 1;
  localparam logic [NR-1:0] ONES      = '1;
  localparam logic [NR-1:0] BR_FLUSH  = NR'((1 << BR_REG) - 1);
  localparam logic [NR-1:0] MD_ENABLE = ONES << MD_REG;
  localparam logic [NR-1:0] MD_FLUSH  = NR'(1 << MD_REG);
  localparam logic [NR-1:0] LU_ENABLE = ONES << (LU_REG + 1);
  localparam logic [NR-1:0] LU_FLUSH  = NR'(1 << LU_REG);
  typedef enum logic {RUN, MD_WAIT} state_e;
  state_e               fsm_q, fsm_d;
  logic [7:0]           md_cnt_q, md_cnt_d;
  logic                 br_pending_q, br_pending_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;
  logic                 pc_we, br_flush;
  logic [NR-1:0]        reg_en, reg_fl;
  always_comb begin
    fsm_d        = fsm_q;
    md_cnt_d     = md_cnt_q;
    br_pending_d = br_pending_q;
    pc_we        = 1'b1;
    reg_en       = '1;
    reg_fl       = '0;
    br_flush     = !hs.memory_busy && (hs.branch_hazard || br_pending_q);
    if (hs.memory_busy) begin
      pc_we        = 1'b0;
      reg_en       = '0;
      br_pending_d = br_pending_q | hs.branch_hazard;
    end else if (br_flush) begin
      reg_fl       = BR_FLUSH;
      br_pending_d = 1'b0;
    end else if (fsm_q == MD_WAIT) begin
      pc_we  = 1'b0;
      reg_en = MD_ENABLE;
      reg_fl = MD_FLUSH;
    end else if (hs.load_use_hazard) begin
      pc_we  = 1'b0;
      reg_en = LU_ENABLE;
      reg_fl = LU_FLUSH;
    end
    // the mul/div unit keeps counting through memory stalls; only a flush aborts it
    if (br_flush) begin
      fsm_d    = RUN;
      md_cnt_d = '0;
    end else if (fsm_q == MD_WAIT) begin
      fsm_d    = (md_cnt_q == '0) ? RUN : MD_WAIT;
      md_cnt_d = (md_cnt_q == '0) ? '0 : md_cnt_q - 8'd1;
    end else if (hs.muldiv_start && !hs.memory_busy) begin
      fsm_d    = MD_WAIT;
      md_cnt_d = 8'(MULDIV_CYCLES - 1);
    end
    stall_d = (!pc_we && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    flush_d = (br_flush && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    if (rst) begin
      pc_we  = 1'b0;
      reg_en = '0;
      reg_fl = '1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= RUN;
      md_cnt_q     <= '0;
      br_pending_q <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      fsm_q        <= fsm_d;
      md_cnt_q     <= md_cnt_d;
      br_pending_q <= br_pending_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end
  assign hs.pc_write_enable = pc_we;
  assign hs.reg_enable      = reg_en;
  assign hs.reg_flush       = reg_fl;
  assign hs.stall_cycles    = stall_q;
  assign hs.flush_count     = flush_q;
  assign hs.md_busy         = (fsm_q == MD_WAIT);
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: random + directed stimulus checked against a behavioural model
module tb_hazard_stall_unit;
  localparam int NS = 5;
  localparam int NR = NS - 1;
  localparam int LU = 1;
  localparam int BR = 2;
  localparam int MD = 2;
  localparam int MC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  hazard_stall_if #(.NUM_STAGES(NS), .CNT_WIDTH(32)) hs ();
  hazard_stall_if #(.NUM_STAGES(NS), .CNT_WIDTH(4))  hs4 ();
  assign hs4.load_use_hazard = hs.load_use_hazard;
  assign hs4.branch_hazard   = hs.branch_hazard;
  assign hs4.memory_busy     = hs.memory_busy;
  assign hs4.muldiv_start    = hs.muldiv_start;
  hazard_stall_unit #(.NUM_STAGES(NS), .LU_REG(LU), .BR_REG(BR), .MD_REG(MD),
    .MULDIV_CYCLES(MC), .CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .hs(hs));
  hazard_stall_unit #(.NUM_STAGES(NS), .LU_REG(LU), .BR_REG(BR), .MD_REG(MD),
    .MULDIV_CYCLES(MC), .CNT_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .hs(hs4));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // model state: remaining mul/div stall cycles, deferred branch, raw event counts
  int  m_rem = 0;
  bit  m_pend = 0;
  int  m_stall = 0;
  int  m_flush = 0;
  bit  synced = 0;
  always @(negedge clk) begin
    logic e_pc;
    logic [NR-1:0] e_en, e_fl;
    bit flush;
    #2;
    flush = !hs.memory_busy && (hs.branch_hazard || m_pend);
    e_pc = 1'b1;
    for (int i = 0; i < NR; i++) begin
      e_en[i] = 1'b1;
      e_fl[i] = 1'b0;
      if (rst) begin e_en[i] = 1'b0; e_fl[i] = 1'b1; end
      else if (hs.memory_busy) e_en[i] = 1'b0;
      else if (flush) e_fl[i] = (i < BR);
      else if (m_rem > 0) begin e_en[i] = (i >= MD); e_fl[i] = (i == MD); end
      else if (hs.load_use_hazard) begin e_en[i] = (i > LU); e_fl[i] = (i == LU); end
    end
    if (rst || hs.memory_busy) e_pc = 1'b0;
    else if (!flush && (m_rem > 0 || hs.load_use_hazard)) e_pc = 1'b0;
    if (rst || synced) begin
      chk("pc_we", 32'(hs.pc_write_enable), 32'(e_pc));
      chk("reg_enable", 32'(hs.reg_enable), 32'(e_en));
      chk("reg_flush", 32'(hs.reg_flush), 32'(e_fl));
    end
    if (synced) begin
      chk("md_busy", 32'(hs.md_busy), 32'(m_rem > 0));
      chk("stall32", hs.stall_cycles, 32'(m_stall));
      chk("flush32", hs.flush_count, 32'(m_flush));
      chk("stall4", 32'(hs4.stall_cycles), 32'(m_stall > 15 ? 15 : m_stall));
      chk("flush4", 32'(hs4.flush_count), 32'(m_flush > 15 ? 15 : m_flush));
    end
    if (rst) begin
      m_rem = 0; m_pend = 0; m_stall = 0; m_flush = 0; synced = 1;
    end else begin
      if (!e_pc) m_stall++;
      if (flush) m_flush++;
      if (hs.memory_busy) m_pend = m_pend || hs.branch_hazard;
      else if (flush) m_pend = 0;
      if (flush) m_rem = 0;
      else if (m_rem > 0) m_rem--;
      else if (hs.muldiv_start && !hs.memory_busy) m_rem = MC;
    end
  end
  task automatic cyc(input logic r, input logic lu, input logic br, input logic mb, input logic ms);
    @(negedge clk);
    rst = r;
    hs.load_use_hazard = lu;
    hs.branch_hazard = br;
    hs.memory_busy = mb;
    hs.muldiv_start = ms;
    #3;
  endtask
  initial begin
    hs.load_use_hazard = 0;
    hs.branch_hazard = 0;
    hs.memory_busy = 0;
    hs.muldiv_start = 0;
    cyc(1, 0, 0, 0, 0);
    chk("rst_pc", 32'(hs.pc_write_enable), 32'd0);
    chk("rst_flush_vec", 32'(hs.reg_flush), 32'hF);
    cyc(0, 0, 0, 0, 0);
    chk("idle_pc", 32'(hs.pc_write_enable), 32'd1);
    chk("idle_stall", hs.stall_cycles, 32'd0);
    cyc(0, 1, 0, 0, 0);
    chk("lu_pc", 32'(hs.pc_write_enable), 32'd0);
    chk("lu_en", 32'(hs.reg_enable), 32'b1100);
    chk("lu_fl", 32'(hs.reg_flush), 32'b0010);
    cyc(0, 0, 0, 0, 0);
    chk("lu_stall_cnt", hs.stall_cycles, 32'd1);
    cyc(0, 0, 1, 0, 0);
    chk("br_en", 32'(hs.reg_enable), 32'b1111);
    chk("br_fl", 32'(hs.reg_flush), 32'b0011);
    cyc(0, 0, 0, 0, 0);
    chk("br_flush_cnt", hs.flush_count, 32'd1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("mb_en", 32'(hs.reg_enable), 32'b0000);
    chk("mb_fl", 32'(hs.reg_flush), 32'b0000);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("deferred_fl", 32'(hs.reg_flush), 32'b0011);
    cyc(0, 0, 0, 0, 0);
    chk("mb_stall_cnt", hs.stall_cycles, 32'd3);
    chk("mb_flush_cnt", hs.flush_count, 32'd1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < MC; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("md_en", 32'(hs.reg_enable), 32'b1100);
      chk("md_fl", 32'(hs.reg_flush), 32'b0100);
      chk("md_busy_on", 32'(hs.md_busy), 32'd1);
    end
    cyc(0, 0, 0, 0, 0);
    chk("md_done", 32'(hs.md_busy), 32'd0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("md_mb_last", 32'(hs.md_busy), 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("md_mb_done", 32'(hs.md_busy), 32'd0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("md_br_fl", 32'(hs.reg_flush), 32'b0011);
    cyc(0, 0, 0, 0, 0);
    chk("md_br_abort", 32'(hs.md_busy), 32'd0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("sat4", 32'(hs4.stall_cycles), 32'hF);
    chk("nosat32", hs.stall_cycles, 32'd20);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_md_busy", 32'(hs.md_busy), 32'd0);
    chk("rst_stall", hs.stall_cycles, 32'd0);
    for (int i = 0; i < 3000; i++)
      cyc(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 9) < 3),
          logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 9) < 2),
          logic'($urandom_range(0, 9) == 0));
    cyc(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
